// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Brief    : Multi-cycle radix-2 restoring divider (DIV/DIVU), {rem, quo} out.
// Revision : 1.0 - initial release
// ============================================================================
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               dbz_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvs;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;
    logic               r_dbz;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;

    assign w_accept = start_i && !annul_i;
    assign w_last   = (r_cnt == c_LAST);

    // Two's-complement magnitude; the most-negative value maps onto itself,
    // which is exactly its unsigned magnitude.
    assign w_abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + c_ONE) : opdata1_i;
    assign w_abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + c_ONE) : opdata2_i;

    // One restoring step: shift in the next dividend bit, trial-subtract.
    assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_dvs};
    assign w_rem_next = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_quo_next = {r_dvd[WIDTH-2:0], ~w_trial[WIDTH]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FREE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FREE: begin
                if (w_accept) begin
                    w_state_next = (opdata2_i == '0) ? BYZERO : ON;
                end
            end
            BYZERO: w_state_next = END;
            ON: begin
                if (annul_i) begin
                    w_state_next = FREE;
                end else if (w_last) begin
                    w_state_next = END;
                end
            end
            END: begin
                if (!start_i || annul_i) begin
                    w_state_next = FREE;
                end
            end
            default: w_state_next = FREE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_ready  <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            case (r_state)
                FREE: begin
                    r_ready  <= 1'b0;
                    r_result <= '0;
                    r_dbz    <= 1'b0;
                    if (w_accept && (opdata2_i != '0)) begin
                        r_neg_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        r_neg_r <= signed_div_i && opdata1_i[WIDTH-1];
                        r_dvd   <= w_abs1;
                        r_dvs   <= w_abs2;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                    end
                end
                BYZERO: begin
                    r_result <= '0;
                    r_dbz    <= 1'b1;
                end
                ON: begin
                    if (annul_i) begin
                        r_result <= '0;
                        r_ready  <= 1'b0;
                    end else begin
                        r_rem <= w_rem_next;
                        r_dvd <= w_quo_next;
                        r_cnt <= r_cnt + c_CNT_ONE;
                        if (w_last) begin
                            r_result <= {(r_neg_r ? -w_rem_next : w_rem_next),
                                         (r_neg_q ? -w_quo_next : w_quo_next)};
                            r_dbz    <= 1'b0;
                        end
                    end
                end
                END: begin
                    if (!start_i || annul_i) begin
                        r_ready  <= 1'b0;
                        r_result <= '0;
                        r_dbz    <= 1'b0;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;
    assign dbz_o    = r_dbz;
    assign busy_o   = (r_state == BYZERO) || (r_state == ON);

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_iter
// Brief    : Self-checking bench for div_iter against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_iter;

    localparam int WIDTH = 32;

    logic               clk;
    logic               rst;
    logic               signed_div_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic               start_i;
    logic               annul_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               busy_o;
    logic               dbz_o;

    int n_checks = 0;
    int n_fail   = 0;

    div_iter #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o),
        .dbz_o        (dbz_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division on magnitudes, then sign rules.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint ma, mb, q, r;
        logic   na, nb;
        if (b == 0) return 64'h0;
        na = sgn && a[31];
        nb = sgn && b[31];
        ma = na ? (64'sd4294967296 - longint'({32'h0, a})) : longint'({32'h0, a});
        mb = nb ? (64'sd4294967296 - longint'({32'h0, b})) : longint'({32'h0, b});
        q  = ma / mb;
        r  = ma % mb;
        if (na != nb) q = -q;
        if (na)       r = -r;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        logic [63:0] exp;
        int          n;
        int          lat;
        logic        busy_bad;
        logic        stable_bad;
        exp        = ref_div(sgn, a, b);
        lat        = (b == 0) ? 2 : WIDTH + 1;
        busy_bad   = 1'b0;
        stable_bad = 1'b0;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        @(posedge clk); #1;
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        n = 0;
        while (!ready_o && n < 100) begin
            if (busy_o !== ((b != 0) ? (n < WIDTH) : (n < 1))) busy_bad = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            check_eq({tag, "_timeout"}, 64'(n), 64'(lat));
        end else begin
            check_eq({tag, "_latency"}, 64'(n), 64'(lat));
            check_eq({tag, "_result"}, result_o, exp);
            check_eq({tag, "_dbz"}, 64'(dbz_o), 64'(b == 0));
            check_eq({tag, "_busy"}, 64'(busy_bad), 64'(0));
            repeat (hold) begin
                @(posedge clk); #1;
                if (ready_o !== 1'b1 || result_o !== exp || dbz_o !== (b == 0)) stable_bad = 1'b1;
            end
            if (hold > 0) check_eq({tag, "_hold"}, 64'(stable_bad), 64'(0));
        end
        start_i = 1'b0;
        @(posedge clk); #1;
        check_eq({tag, "_drop"}, {ready_o, busy_o, dbz_o, result_o[60:0]}, 64'h0);
    endtask

    initial begin
        logic        ready_seen;
        logic [31:0] ra, rb;
        logic        rs;
        rst = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        start_i = 1'b0;
        annul_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_state", {ready_o, busy_o, dbz_o, result_o[60:0]}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        run_op("s7_m2",   1'b1, 32'd7,        32'hFFFFFFFE, 0);
        run_op("u_ffff",  1'b0, 32'hFFFFFFFF, 32'h00000010, 0);
        run_op("sm7_2",   1'b1, 32'hFFFFFFF9, 32'd2,        0);
        run_op("dbz",     1'b1, 32'h12345678, 32'd0,        1);
        run_op("min_m1",  1'b1, 32'h80000000, 32'hFFFFFFFF, 5);
        run_op("u_min_1", 1'b0, 32'h80000000, 32'hFFFFFFFF, 0);

        // Annul in the middle of an operation, then restart immediately.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        @(posedge clk); #1;
        ready_seen = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
            if (ready_o) ready_seen = 1'b1;
        end
        annul_i = 1'b1;
        @(posedge clk); #1;
        check_eq("annul_free", {ready_seen, ready_o, busy_o, result_o[60:0]}, 64'h0);
        @(posedge clk); #1;
        check_eq("annul_ignore_start", 64'(busy_o), 64'h0);
        annul_i = 1'b0;
        run_op("after_annul", 1'b0, 32'd100, 32'd3, 0);

        // Asynchronous reset partway through the iterations.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        @(posedge clk); #1;
        repeat (17) @(posedge clk);
        #3;
        check_eq("pre_reset_busy", 64'(busy_o), 64'h1);
        rst     = 1'b1;
        start_i = 1'b0;
        #1;
        check_eq("async_reset", {ready_o, busy_o, dbz_o, result_o[60:0]}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_reset", 1'b0, 32'd9, 32'd3, 0);

        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2:       rb = 32'($urandom_range(1, 15));
                3:       rb = 32'h80000000;
                default: rb = $urandom;
            endcase
            run_op("rand", rs, ra, rb, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_iter.md
Name: div_iter

Overview:
- Parametrised multi-cycle radix-2 restoring divider for the EX stage. Executes DIV and DIVU.
- Called when EX decodes a divide op. Result is written to HI/LO through the existing whilo path: remainder goes to HI, quotient to LO.
- Supports signed/unsigned mode, divide-by-zero detection and annulment. EX stalls the pipeline while busy_o is high.

Parameters:
- WIDTH, 32, operand width in bits (≥2).
- CNT_W, $clog2(WIDTH+1), width of the iteration counter (localparam).

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  asynchronous reset, active-high.
- signed_div_i  input  1  1=signed (DIV), 0=unsigned (DIVU); sampled at start.
- opdata1_i  input  WIDTH  dividend; sampled at start.
- opdata2_i  input  WIDTH  divisor; sampled at start.
- start_i  input  1  request. Level-held by EX until ready_o is seen.
- annul_i  input  1  abort the current operation (flush/exception).
- result_o  output  2*WIDTH  {remainder, quotient}.
- ready_o  output  1  result valid.
- busy_o  output  1  operation in progress (state BYZERO or ON).
- dbz_o  output  1  divide-by-zero flag; valid while ready_o=1.

Behaviour:
- Reset: async. State=FREE, result_o=0, ready_o=0, dbz_o=0, busy_o=0, counter=0, datapath registers=0. Reset mid-operation discards all work.
- States: FREE, BYZERO, ON, END. All outputs are registered except busy_o, which is a state decode.
- FREE:
  - start_i=1, annul_i=0, opdata2_i=0 → BYZERO.
  - start_i=1, annul_i=0, opdata2_i≠0 → ON. On the same edge:
    - latch signed_div_i and the operand signs;
    - load |opdata1_i| and |opdata2_i| (raw values when unsigned);
    - clear the counter and the partial remainder.
  - start_i=1 together with annul_i=1 → ignored, stay FREE.
  - ready_o=0 in FREE.
- BYZERO: next edge → END with result_o=0, dbz_o=1.
- ON, one iteration per edge:
  - shift {partial remainder, dividend} left by 1;
  - trial-subtract the divisor;
  - if non-negative, keep the difference and set quotient bit = 1; else restore and set bit = 0;
  - counter += 1.
- ON completion: on the edge where counter reaches WIDTH → END. Same edge applies sign correction (signed mode only):
  - quotient negated if the dividend and divisor signs differ;
  - remainder takes the dividend's sign.
  - dbz_o=0.
- ON annulment: annul_i=1 in ON has priority over iteration. Next edge → FREE, result_o=0, ready_o=0.
- END:
  - ready_o=1; result_o and dbz_o hold stable.
  - Stays in END while start_i=1, to absorb pipeline stall.
  - start_i=0 → FREE on next edge; ready_o=0, result_o=0.
  - annul_i in END → FREE on next edge (same as start_i=0).
- Latency: start sampled at edge E. Non-zero divisor: ready_o rises after edge E+WIDTH+1. Zero divisor: ready_o rises after edge E+2.
- Arithmetic rules:
  - Absolute value is computed as ~x+1 in WIDTH bits, so the most-negative value maps to itself and is treated as unsigned magnitude 2^(WIDTH-1).
  - Signed MIN / -1 → quotient=MIN (wraps), remainder=0. No overflow flag.
  - Unsigned mode never applies sign correction.
- Operand inputs are ignored outside the FREE accept edge. Changing them mid-operation has no effect.

Test Plan:
- WIDTH=32, signed, opdata1=7, opdata2=0xFFFFFFFE (-2), start held → after edge E+33: ready_o=1, result_o={0x00000001, 0xFFFFFFFD}, dbz_o=0. busy_o=1 for edges E+1..E+32.
- Unsigned, 0xFFFFFFFF / 0x00000010 → result_o={0x0000000F, 0x0FFFFFFF}. Signed, 0xFFFFFFF9 (-7) / 2 → result_o={0xFFFFFFFF, 0xFFFFFFFD}.
- Signed, opdata2=0 with opdata1=0x12345678 → ready_o=1 after edge E+2, dbz_o=1, result_o=0. Deassert start_i → ready_o=0 next edge.
- Signed, 0x80000000 / 0xFFFFFFFF → result_o={0x00000000, 0x80000000}. Hold start_i 5 extra cycles → ready_o and result_o stay stable. Drop start_i → FREE.
- Annul: start 100/3, assert annul_i at the 10th ON cycle → FREE next edge, ready_o never rises. Immediate new start 100/3 → result_o={1, 33}.
- Reset: assert rst asynchronously mid-ON (counter=17) → outputs are 0 immediately without waiting for a clock edge. After release, start 9/3 unsigned → result_o={0, 3} at the nominal latency.
